fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/mips_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 107 ++++++++++
 tb/tb_fetch_unit.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared front-end constants, fetch FSM encoding and the buffered-instruction entry type.
package mips_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          FETCH_DEPTH      = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer of DEPTH {pc, word} entries; a pushed entry is visible at the head next cycle.
// No backpressure of its own: the fetch credit scheme keeps it from overflowing; clear empties it.
module fetch_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  fetch_entry_t push_dat,
  input  logic         pop,
  input  logic         clear,
  output fetch_entry_t head,
  output logic [AW:0]  count
);

  fetch_entry_t  mem [DEPTH];
  fetch_entry_t  last_q;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && (count_q != (AW+1)'(DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      last_q  <= '0;
    end else begin
      last_q <= head;
      if (clear) begin
        rd_ptr  <= '0;
        wr_ptr  <= '0;
        count_q <= '0;
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= push_dat;
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
    end
  end

  // When empty, keep presenting the last head rather than a stale slot.
  assign head  = (count_q != '0) ? mem[rd_ptr] : last_q;
  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: credit-limited requests to imem, in-order responses buffered in fetch_fifo.
// Returned word visible one cycle later; requests pause while buffered + in-flight words reach DEPTH.
module fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = FETCH_DEPTH
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] instruction,
  output logic [31:0] inst_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_addr
);

  localparam int CW = $clog2(DEPTH) + 1;

  fetch_state_e  state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [31:0]   target;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] occupancy, occupancy_d, credit_d;
  logic          grant, push, pop;
  fetch_entry_t  resp_entry, head;

  assign target     = {redirect_addr[31:2], 2'b00};
  assign grant      = imem_req && imem_gnt;
  assign pop        = inst_valid && inst_ready;
  assign push       = imem_rvalid && (drop_q == '0) && !redirect;
  assign resp_entry = {resp_pc_q, imem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_dat (resp_entry),
    .pop      (pop),
    .clear    (redirect),
    .head     (head),
    .count    (occupancy)
  );

  // Responses arrive in order, so the first kept response after a redirect belongs to the target.
  always_comb begin
    outstanding_d = outstanding_q + CW'(grant) - CW'(imem_rvalid);
    drop_d        = drop_q;
    if (redirect)                           drop_d = outstanding_d;
    else if (imem_rvalid && drop_q != '0)   drop_d = drop_q - CW'(1);
    pc_d = pc_q;
    if (redirect)   pc_d = target;
    else if (grant) pc_d = pc_q + 32'd4;
    resp_pc_d = resp_pc_q;
    if (redirect)  resp_pc_d = target;
    else if (push) resp_pc_d = resp_pc_q + 32'd4;
    occupancy_d = redirect ? '0 : occupancy + CW'(push) - CW'(pop);
    credit_d    = CW'(DEPTH) - occupancy_d - outstanding_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      resp_pc_q     <= resp_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (credit_d == '0) state_d = ST_STALL;
      ST_STALL: if (credit_d != '0) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req  = (state_q == ST_FETCH);
    imem_addr = pc_q;
  end

  assign inst_valid  = (occupancy != '0);
  assign instruction = head.word;
  assign inst_pc     = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: in-order memory model with variable latency, queue-based reference model
// checked every cycle at the falling edge, plus directed scenarios with literal expectations.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam int          D   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] instruction;
  logic [31:0] inst_pc;
  logic        redirect = 1'b0;
  logic [31:0] redirect_addr = 32'h0;

  fetch_unit #(.RESET_PC(RPC), .DEPTH(D)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .instruction   (instruction),
    .inst_pc       (inst_pc),
    .redirect      (redirect),
    .redirect_addr (redirect_addr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory: in-order responses, latency drawn per grant
  typedef struct { logic [31:0] addr; int due; } mreq_t;
  mreq_t mq[$];
  int cyc = 0, last_due = 0;
  int lat_min = 1, lat_max = 1;
  int gnt_mode = 0, ready_mode = 0;

  // reference model
  logic [31:0] m_pc;
  int          m_out, m_drop;
  bit          m_idle;
  logic [31:0] m_bpc[$], m_bw[$], m_inflight[$];

  logic [31:0] glog[$], plog_pc[$], plog_w[$];

  function automatic logic [31:0] mword(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_at(input string name, input logic [31:0] q[$], input int idx, input logic [31:0] exp);
    if (idx < q.size()) chk(name, q[idx], exp);
    else begin
      checks++;
      errors++;
      $display("FAIL %s actual=missing required=%h", name, exp);
    end
  endtask

  function automatic bit pick(input int mode);
    if (mode == 1) return 1'b1;
    if (mode == 2) return $urandom_range(0, 1) == 1;
    return 1'b0;
  endfunction

  task automatic clear_logs();
    glog.delete(); plog_pc.delete(); plog_w.delete();
  endtask

  // One cycle, entered and left at a falling edge.
  task automatic step(input bit rd = 1'b0, input logic [31:0] ra = 32'h0);
    bit m_req, m_grant, g, rdy, rv;
    int d;
    logic [31:0] rpc;
    m_req = !m_idle && (D - m_bpc.size() - m_out) > 0;
    chk("imem_req", imem_req, m_req);
    if (m_req) chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", inst_valid, m_bpc.size() != 0);
    if (m_bpc.size() != 0) begin
      chk("instruction", instruction, m_bw[0]);
      chk("inst_pc", inst_pc, m_bpc[0]);
    end

    rv = (mq.size() != 0) && (mq[0].due <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? mword(mq[0].addr) : 32'hDEAD_DEAD;
    if (rv) void'(mq.pop_front());
    g   = pick(gnt_mode);
    rdy = pick(ready_mode);
    imem_gnt = g; inst_ready = rdy; redirect = rd; redirect_addr = ra;

    if (imem_req && g) begin
      d = cyc + $urandom_range(lat_min, lat_max);
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      mq.push_back('{addr: imem_addr, due: d});
      glog.push_back(imem_addr);
    end
    if (inst_valid && rdy) begin
      plog_pc.push_back(inst_pc);
      plog_w.push_back(instruction);
    end

    m_grant = m_req && g;
    if (m_bpc.size() != 0 && rdy) begin
      void'(m_bpc.pop_front());
      void'(m_bw.pop_front());
    end
    if (rv) begin
      m_out--;
      rpc = (m_inflight.size() != 0) ? m_inflight.pop_front() : 32'hBAD0_BAD0;
      if (m_drop > 0) m_drop--;
      else if (!rd) begin
        m_bpc.push_back(rpc);
        m_bw.push_back(mword(rpc));
      end
    end
    if (rd) begin m_bpc.delete(); m_bw.delete(); end
    if (m_grant) begin m_out++; m_inflight.push_back(m_pc); end
    if (rd) m_drop = m_out;
    if (rd) m_pc = {ra[31:2], 2'b00};
    else if (m_grant) m_pc = m_pc + 32'd4;
    m_idle = 1'b0;
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0; redirect = 1'b0;
    #1;
    chk("rst imem_req", imem_req, 0);
    chk("rst imem_addr", imem_addr, RPC);
    chk("rst inst_valid", inst_valid, 0);
    chk("rst instruction", instruction, 0);
    chk("rst inst_pc", inst_pc, 0);
    mq.delete(); m_bpc.delete(); m_bw.delete(); m_inflight.delete();
    m_out = 0; m_drop = 0; m_idle = 1'b1; m_pc = RPC; last_due = cyc;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #3;
    // sequential fill, stall at DEPTH, single refill after one pop
    gnt_mode = 1; ready_mode = 0; lat_min = 1; lat_max = 1;
    do_reset();
    clear_logs();
    repeat (10) step();
    chk("fill grant count", glog.size(), 4);
    for (int i = 0; i < 4; i++) chk_at("fill addr", glog, i, i * 4);
    chk("stall imem_req", imem_req, 0);
    ready_mode = 1; step();
    ready_mode = 0; repeat (6) step();
    chk("refill grant count", glog.size(), 5);
    chk_at("refill addr", glog, 4, 32'h10);
    chk_at("first pop pc", plog_pc, 0, 32'h0);
    chk_at("first pop word", plog_w, 0, 32'hC0DE_0000);
    ready_mode = 1; repeat (8) step();
    for (int i = 1; i < 5; i++) chk_at("drain pc", plog_pc, i, i * 4);
    chk_at("drain word", plog_w, 4, 32'hC0DE_0010);

    // redirect with two outstanding, request withdrawn, unaligned target
    lat_min = 3; lat_max = 3; gnt_mode = 1; ready_mode = 1;
    do_reset();
    repeat (3) step();
    gnt_mode = 0;
    step(1'b1, 32'h0000_0103);
    clear_logs();
    gnt_mode = 1;
    repeat (12) step();
    chk_at("redir first addr", glog, 0, 32'h100);
    chk_at("redir first pc", plog_pc, 0, 32'h100);
    chk_at("redir first word", plog_w, 0, 32'hC0DE_0100);

    // back-to-back redirects while fetching, last wins
    step(1'b1, 32'h300);
    step(1'b1, 32'h400);
    clear_logs();
    repeat (12) step();
    chk_at("b2b first addr", glog, 0, 32'h400);
    chk_at("b2b first pc", plog_pc, 0, 32'h400);

    // redirect coincident with grant and pop
    lat_min = 1; lat_max = 1; gnt_mode = 1; ready_mode = 0;
    do_reset();
    clear_logs();
    repeat (3) step();
    ready_mode = 1;
    step(1'b1, 32'h200);
    chk_at("coinc granted addr", glog, 2, 32'h8);
    chk_at("coinc popped pc", plog_pc, 0, 32'h0);
    clear_logs();
    repeat (6) step();
    chk_at("coinc next addr", glog, 0, 32'h200);
    chk_at("coinc next pc", plog_pc, 0, 32'h200);

    // address wrap
    step(1'b1, 32'hFFFF_FFFF);
    clear_logs();
    repeat (6) step();
    chk_at("wrap addr0", glog, 0, 32'hFFFF_FFFC);
    chk_at("wrap addr1", glog, 1, 32'h0);
    chk_at("wrap pc0", plog_pc, 0, 32'hFFFF_FFFC);
    chk_at("wrap pc1", plog_pc, 1, 32'h0);
    chk_at("wrap word1", plog_w, 1, 32'hC0DE_0000);

    // reset mid-stream with full buffer
    ready_mode = 0;
    repeat (10) step();
    chk("full before reset", inst_valid, 1);
    do_reset();
    clear_logs();
    gnt_mode = 1;
    repeat (4) step();
    chk_at("restart addr0", glog, 0, RPC);
    chk_at("restart addr1", glog, 1, RPC + 32'd4);

    // mixed traffic
    gnt_mode = 2; ready_mode = 2; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 400; i++) step($urandom_range(0, 9) == 0, $urandom);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
